// File: rtl/seq_shift_add_mult.sv
// seq_shift_add_mult: multi-cycle shift-add multiplier with start/busy/done/ack handshake,
// operating on magnitudes and applying the sign once at the end.
module seq_shift_add_mult #(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               ack,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state, state_nx;
    logic               neg;
    logic               sgn;
    logic               last;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] preg;
    logic [CW-1:0]      cnt;

    assign sgn   = SIGNED_EN & signed_mode;
    assign a_mag = (sgn && a[WIDTH-1]) ? -a : a;
    assign b_mag = (sgn && b[WIDTH-1]) ? -b : b;
    // carry out of the upper half is kept and shifted back in
    assign sum   = {1'b0, preg[2*WIDTH-1:WIDTH]} + (preg[0] ? {1'b0, mcand} : '0);
    assign last  = cnt == CW'(WIDTH - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = (state == CALC) || (state == FIX);
        done     = state == DONE;
        unique case (state)
            IDLE: state_nx = start ? CALC : IDLE;
            CALC: state_nx = last ? FIX : CALC;
            FIX:  state_nx = DONE;
            DONE: state_nx = ack ? IDLE : DONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            neg     <= 1'b0;
            mcand   <= '0;
            preg    <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    neg   <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                    mcand <= a_mag;
                    preg  <= {{WIDTH{1'b0}}, b_mag};
                    cnt   <= '0;
                end
                CALC: begin
                    preg <= {sum, preg[WIDTH-1:1]};
                    cnt  <= cnt + 1'b1;
                end
                FIX:  product <= neg ? -preg : preg;
                DONE: ;
            endcase
        end
    end
endmodule
